dc_bu_read_manager: RTL and testbench

- Read-side counterpart of the buffering-unit line-buffer write path.
- On a start pulse, sweeps read addresses 0..N-1 across one selected line buffer and drives per-buffer read enables.
- Tracks the 1-cycle RAM read latency and presents a valid/ready pixel stream to the downstream scaler datapath, with backpressure.

---
 rtl/dc_bu_pkg.sv | 17 +
 rtl/dc_bu_read_manager_if.sv | 48 ++++
 rtl/dc_bu_rd_valid_tracker.sv | 46 ++++
 rtl/dc_bu_read_manager.sv | 148 ++++++++++++++
 tb/tb_dc_bu_read_manager.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dc_bu_pkg.sv
// dc_bu_pkg
// Shared definitions for the buffering-unit line-buffer managers.
//   rd_state_e           : read manager state encoding (IDLE, READ, DRAIN)
//   DEFAULT_BUFFER_NUM   : default number of line buffers
//   DEFAULT_BUFFER_SIZE  : default entries per line buffer
package dc_bu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int DEFAULT_BUFFER_NUM  = 5;
  localparam int DEFAULT_BUFFER_SIZE = 128;

endpackage

// File: rtl/dc_bu_read_manager_if.sv
// dc_bu_read_manager_if
// Line-request and pixel-stream signals between a line consumer (master)
// and the line-buffer read manager (slave).
//   pixels_per_line, start_line, read_buffer_id, out_ready : master -> slave
//   mem_addr, re_vec, rd_sel, pix_valid, line_done, busy    : slave -> master
// Optional feature macro DC_BU_RD_PIXEL_DOUBLE_EN adds pixel_double
// (master -> slave), which sends every address twice.
interface dc_bu_read_manager_if #(
  parameter int BUFF_ADDR_WIDTH       = 7,
  parameter int BUFFER_NUM            = 5,
  parameter int PIXELS_PER_LINE_WIDTH = 8
);

  logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line;
  logic                             start_line;
  logic [BUFFER_NUM-1:0]            read_buffer_id;
  logic                             out_ready;
`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
  logic                             pixel_double;
`endif
  logic [BUFF_ADDR_WIDTH-1:0]       mem_addr;
  logic [BUFFER_NUM-1:0]            re_vec;
  logic [BUFFER_NUM-1:0]            rd_sel;
  logic                             pix_valid;
  logic                             line_done;
  logic                             busy;

`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
  modport master (
    output pixels_per_line, start_line, read_buffer_id, out_ready, pixel_double,
    input  mem_addr, re_vec, rd_sel, pix_valid, line_done, busy
  );
  modport slave (
    input  pixels_per_line, start_line, read_buffer_id, out_ready, pixel_double,
    output mem_addr, re_vec, rd_sel, pix_valid, line_done, busy
  );
`else
  modport master (
    output pixels_per_line, start_line, read_buffer_id, out_ready,
    input  mem_addr, re_vec, rd_sel, pix_valid, line_done, busy
  );
  modport slave (
    input  pixels_per_line, start_line, read_buffer_id, out_ready,
    output mem_addr, re_vec, rd_sel, pix_valid, line_done, busy
  );
`endif

endinterface

// File: rtl/dc_bu_rd_valid_tracker.sv
// dc_bu_rd_valid_tracker
// Valid tracking for a RAM with 1-cycle read latency feeding a valid/ready
// stream. A read is issued only when the output slot is empty or is being
// drained in the same cycle, so held RAM data is never overwritten.
//   clk, rst     : clock, async active-high reset
//   en           : global enable; freezes pix_valid and blocks issue/accept
//   read_active  : the reader wants to issue reads this cycle
//   out_ready    : downstream accepts the current pixel
//   issue        : a read is launched this cycle
//   accept       : the current pixel is consumed this cycle
//   pix_valid    : RAM output holds a valid pixel
module dc_bu_rd_valid_tracker (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic read_active,
  input  logic out_ready,
  output logic issue,
  output logic accept,
  output logic pix_valid
);

  logic pix_valid_q, pix_valid_d;

  assign issue     = en && read_active && (!pix_valid_q || out_ready);
  assign accept    = en && pix_valid_q && out_ready;
  assign pix_valid = pix_valid_q;

  always_comb begin
    pix_valid_d = pix_valid_q;
    if (issue) begin
      pix_valid_d = 1'b1;
    end else if (accept) begin
      pix_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
    end else begin
      pix_valid_q <= pix_valid_d;
    end
  end

endmodule

// File: rtl/dc_bu_read_manager.sv
// dc_bu_read_manager
// Sweeps addresses 0..N-1 over one selected line buffer on a start pulse and
// presents the RAM output as a valid/ready pixel stream with backpressure.
//   clk, rst : clock, async active-high reset
//   en       : global enable; all state frozen while low
//   bus      : dc_bu_read_manager_if slave (line request in, pixel stream out)
// Optional feature macro DC_BU_RD_PIXEL_DOUBLE_EN: pixel_double, sampled at
// start, presents each address for two accepted beats.
module dc_bu_read_manager
  import dc_bu_pkg::*;
#(
  parameter int BUFF_ADDR_WIDTH       = 7,
  parameter int BUFFER_SIZE           = DEFAULT_BUFFER_SIZE,
  parameter int BUFFER_NUM            = DEFAULT_BUFFER_NUM,
  parameter int PIXELS_PER_LINE_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  en,
  dc_bu_read_manager_if.slave  bus
);

  // Wide enough to hold both pixels_per_line and BUFFER_SIZE untruncated.
  localparam int CNT_W = (PIXELS_PER_LINE_WIDTH > BUFF_ADDR_WIDTH + 1) ?
                         PIXELS_PER_LINE_WIDTH : BUFF_ADDR_WIDTH + 1;

  rd_state_e                  state_q, state_d;
  logic [BUFF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUFFER_NUM-1:0]      buf_id_q, buf_id_d;
  logic [CNT_W-1:0]           n_q, n_d;
  logic                       done_q, done_d;

  logic                       issue, accept, pix_valid;
  logic [CNT_W-1:0]           ppl_ext, n_in;
  logic                       at_last;
  logic                       hold_beat;

`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
  logic dbl_q, dbl_d;
  logic phase_q, phase_d;
  // First beat of a doubled address: reissue it instead of advancing.
  assign hold_beat = dbl_q && !phase_q;
`else
  assign hold_beat = 1'b0;
`endif

  assign ppl_ext = CNT_W'(bus.pixels_per_line);
  assign n_in    = (ppl_ext > CNT_W'(BUFFER_SIZE)) ? CNT_W'(BUFFER_SIZE) : ppl_ext;
  assign at_last = (CNT_W'(addr_q) == (n_q - CNT_W'(1)));

  dc_bu_rd_valid_tracker u_valid (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .read_active (state_q == READ),
    .out_ready   (bus.out_ready),
    .issue       (issue),
    .accept      (accept),
    .pix_valid   (pix_valid)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    buf_id_d = buf_id_q;
    n_d      = n_q;
    // The zero-length pulse survives an en-low cycle so it is not lost.
    done_d   = en ? 1'b0 : done_q;
`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
    dbl_d    = dbl_q;
    phase_d  = phase_q;
`endif
    if (en) begin
      case (state_q)
        IDLE: begin
          if (bus.start_line) begin
            buf_id_d = bus.read_buffer_id;
            n_d      = n_in;
            addr_d   = '0;
`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
            dbl_d    = bus.pixel_double;
            phase_d  = 1'b0;
`endif
            if (n_in == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = READ;
            end
          end
        end
        READ: begin
          if (issue) begin
`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
            phase_d = hold_beat;
`endif
            if (!hold_beat) begin
              if (at_last) begin
                state_d = DRAIN;
              end else begin
                addr_d = addr_q + BUFF_ADDR_WIDTH'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            addr_d  = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      buf_id_q <= '0;
      n_q      <= '0;
      done_q   <= 1'b0;
`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
      dbl_q    <= 1'b0;
      phase_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      buf_id_q <= buf_id_d;
      n_q      <= n_d;
      done_q   <= done_d;
`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
      dbl_q    <= dbl_d;
      phase_q  <= phase_d;
`endif
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.re_vec    = issue ? buf_id_q : '0;
  assign bus.rd_sel    = buf_id_q;
  assign bus.pix_valid = pix_valid;
  // Last pixel accepted this cycle, or the registered zero-length pulse.
  assign bus.line_done = en && (((state_q == DRAIN) && accept) || done_q);
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dc_bu_read_manager.sv
// tb_dc_bu_read_manager
// Self-checking bench for dc_bu_read_manager: a per-cycle vector table for
// the main line sequences plus hand-written multi-cycle corner cases.
module tb_dc_bu_read_manager;

  logic clk;
  logic rst;
  logic en;
  int   checks;
  int   errors;

  dc_bu_read_manager_if #(
    .BUFF_ADDR_WIDTH(7), .BUFFER_NUM(5), .PIXELS_PER_LINE_WIDTH(8)
  ) bus ();

  dc_bu_read_manager #(
    .BUFF_ADDR_WIDTH(7), .BUFFER_SIZE(128), .BUFFER_NUM(5), .PIXELS_PER_LINE_WIDTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backstop so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic       en;
    logic       start;
    logic [7:0] ppl;
    logic [4:0] id;
    logic       ready;
    logic [6:0] eAddr;
    logic [4:0] eRe;
    logic [4:0] eSel;
    logic       ePv;
    logic       eLd;
    logic       eBusy;
  } vec_t;

  localparam int NUM_VECS = 23;
  vec_t vecs [NUM_VECS];

  function automatic vec_t mkVec(logic e, logic s, logic [7:0] p, logic [4:0] i, logic r,
                                 logic [6:0] a, logic [4:0] re, logic [4:0] sel,
                                 logic pv, logic ld, logic bz);
    vec_t v;
    v.en = e; v.start = s; v.ppl = p; v.id = i; v.ready = r;
    v.eAddr = a; v.eRe = re; v.eSel = sel; v.ePv = pv; v.eLd = ld; v.eBusy = bz;
    return v;
  endfunction

  // Drive inputs at the falling edge, then settle before sampling.
  task automatic applyStimulus(input logic e, input logic s, input logic [7:0] p,
                               input logic [4:0] i, input logic r);
    @(negedge clk);
    en                 = e;
    bus.start_line     = s;
    bus.pixels_per_line = p;
    bus.read_buffer_id = i;
    bus.out_ready      = r;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".mem_addr"},  32'(bus.mem_addr),  0);
    checkOutput({tag, ".re_vec"},    32'(bus.re_vec),    0);
    checkOutput({tag, ".rd_sel"},    32'(bus.rd_sel),    0);
    checkOutput({tag, ".pix_valid"}, 32'(bus.pix_valid), 0);
    checkOutput({tag, ".line_done"}, 32'(bus.line_done), 0);
    checkOutput({tag, ".busy"},      32'(bus.busy),      0);
  endtask

  initial begin
    int issues;
    int accepts;
    logic seenDone;
    logic reached;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    en = 1'b0;
    bus.start_line = 1'b0;
    bus.pixels_per_line = '0;
    bus.read_buffer_id = '0;
    bus.out_ready = 1'b0;
`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
    bus.pixel_double = 1'b0;
`endif

    // Reset state
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table: N=4 full rate, N=3 with one stall and an ignored start,
    // N=0, N=3 with en low for 3 cycles (out_ready high but ignored).
    vecs[0]  = mkVec(1,1,8'd4,5'b00100,1, 7'd0,5'b00000,5'b00000,0,0,0);
    vecs[1]  = mkVec(1,0,8'd0,5'b00000,1, 7'd0,5'b00100,5'b00100,0,0,1);
    vecs[2]  = mkVec(1,0,8'd0,5'b00000,1, 7'd1,5'b00100,5'b00100,1,0,1);
    vecs[3]  = mkVec(1,0,8'd0,5'b00000,1, 7'd2,5'b00100,5'b00100,1,0,1);
    vecs[4]  = mkVec(1,0,8'd0,5'b00000,1, 7'd3,5'b00100,5'b00100,1,0,1);
    vecs[5]  = mkVec(1,0,8'd0,5'b00000,1, 7'd3,5'b00000,5'b00100,1,1,1);
    vecs[6]  = mkVec(1,1,8'd3,5'b00010,1, 7'd0,5'b00000,5'b00100,0,0,0);
    vecs[7]  = mkVec(1,0,8'd0,5'b00000,1, 7'd0,5'b00010,5'b00010,0,0,1);
    vecs[8]  = mkVec(1,0,8'd0,5'b00000,0, 7'd1,5'b00000,5'b00010,1,0,1);
    vecs[9]  = mkVec(1,1,8'd7,5'b10000,1, 7'd1,5'b00010,5'b00010,1,0,1);
    vecs[10] = mkVec(1,0,8'd0,5'b00000,1, 7'd2,5'b00010,5'b00010,1,0,1);
    vecs[11] = mkVec(1,0,8'd0,5'b00000,1, 7'd2,5'b00000,5'b00010,1,1,1);
    vecs[12] = mkVec(1,1,8'd0,5'b00001,1, 7'd0,5'b00000,5'b00010,0,0,0);
    vecs[13] = mkVec(1,0,8'd0,5'b00000,1, 7'd0,5'b00000,5'b00001,0,1,0);
    vecs[14] = mkVec(1,1,8'd3,5'b01000,1, 7'd0,5'b00000,5'b00001,0,0,0);
    vecs[15] = mkVec(1,0,8'd0,5'b00000,1, 7'd0,5'b01000,5'b01000,0,0,1);
    vecs[16] = mkVec(0,0,8'd0,5'b00000,1, 7'd1,5'b00000,5'b01000,1,0,1);
    vecs[17] = mkVec(0,0,8'd0,5'b00000,1, 7'd1,5'b00000,5'b01000,1,0,1);
    vecs[18] = mkVec(0,0,8'd0,5'b00000,1, 7'd1,5'b00000,5'b01000,1,0,1);
    vecs[19] = mkVec(1,0,8'd0,5'b00000,1, 7'd1,5'b01000,5'b01000,1,0,1);
    vecs[20] = mkVec(1,0,8'd0,5'b00000,1, 7'd2,5'b01000,5'b01000,1,0,1);
    vecs[21] = mkVec(1,0,8'd0,5'b00000,1, 7'd2,5'b00000,5'b01000,1,1,1);
    vecs[22] = mkVec(1,0,8'd0,5'b00000,1, 7'd0,5'b00000,5'b01000,0,0,0);

    for (int k = 0; k < NUM_VECS; k++) begin
      applyStimulus(vecs[k].en, vecs[k].start, vecs[k].ppl, vecs[k].id, vecs[k].ready);
      checkOutput($sformatf("vec%0d.mem_addr", k),  32'(bus.mem_addr),  32'(vecs[k].eAddr));
      checkOutput($sformatf("vec%0d.re_vec", k),    32'(bus.re_vec),    32'(vecs[k].eRe));
      checkOutput($sformatf("vec%0d.rd_sel", k),    32'(bus.rd_sel),    32'(vecs[k].eSel));
      checkOutput($sformatf("vec%0d.pix_valid", k), 32'(bus.pix_valid), 32'(vecs[k].ePv));
      checkOutput($sformatf("vec%0d.line_done", k), 32'(bus.line_done), 32'(vecs[k].eLd));
      checkOutput($sformatf("vec%0d.busy", k),      32'(bus.busy),      32'(vecs[k].eBusy));
    end

    // Oversized line: 200 requested, clamped to 128 addresses.
    $display("[TB] clamp sequence");
    applyStimulus(1, 1, 8'd200, 5'b00001, 1);
    issues = 0;
    seenDone = 1'b0;
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1, 0, 8'd0, 5'b00000, 1);
      if (bus.re_vec != 5'b0) begin
        checkOutput("clamp.addr", 32'(bus.mem_addr), 32'(issues));
        issues++;
      end
      if (bus.line_done) begin
        seenDone = 1'b1;
        break;
      end
    end
    checkOutput("clamp.issues", 32'(issues), 128);
    checkOutput("clamp.done", 32'(seenDone), 1);

    // Reset in the middle of a 10-pixel line at address 5.
    $display("[TB] mid-line reset sequence");
    applyStimulus(1, 0, 8'd0, 5'b00000, 1);
    applyStimulus(1, 1, 8'd10, 5'b00001, 1);
    reached = 1'b0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 0, 8'd0, 5'b00000, 1);
      if (bus.re_vec != 5'b0 && bus.mem_addr == 7'd5) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("rst.reachedAddr5", 32'(reached), 1);
    rst = 1'b1;
    #1;
    checkAllZero("rstMid");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1, 8'd2, 5'b00001, 1);
    applyStimulus(1, 0, 8'd0, 5'b00000, 1);
    checkOutput("rstRestart.mem_addr", 32'(bus.mem_addr), 0);
    checkOutput("rstRestart.re_vec", 32'(bus.re_vec), 32'(5'b00001));
    seenDone = 1'b0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1, 0, 8'd0, 5'b00000, 1);
      if (bus.line_done) begin
        seenDone = 1'b1;
        break;
      end
    end
    checkOutput("rstRestart.done", 32'(seenDone), 1);

`ifdef DC_BU_RD_PIXEL_DOUBLE_EN
    // Doubled line: addresses 0,0,1,1 and done on the 4th accept.
    begin
      logic [6:0] addrs [4];
      $display("[TB] pixel double sequence");
      applyStimulus(1, 0, 8'd0, 5'b00000, 1);
      bus.pixel_double = 1'b1;
      applyStimulus(1, 1, 8'd2, 5'b00010, 1);
      bus.pixel_double = 1'b0;
      issues = 0;
      accepts = 0;
      seenDone = 1'b0;
      for (int c = 0; c < 20; c++) begin
        applyStimulus(1, 0, 8'd0, 5'b00000, 1);
        if (bus.re_vec != 5'b0) begin
          checkOutput("dbl.re_vec", 32'(bus.re_vec), 32'(5'b00010));
          if (issues < 4) addrs[issues] = bus.mem_addr;
          issues++;
        end
        if (bus.pix_valid && bus.out_ready) accepts++;
        if (bus.line_done) begin
          seenDone = 1'b1;
          checkOutput("dbl.acceptsAtDone", 32'(accepts), 4);
          break;
        end
      end
      checkOutput("dbl.issues", 32'(issues), 4);
      checkOutput("dbl.done", 32'(seenDone), 1);
      if (issues >= 4) begin
        checkOutput("dbl.addr0", 32'(addrs[0]), 0);
        checkOutput("dbl.addr1", 32'(addrs[1]), 0);
        checkOutput("dbl.addr2", 32'(addrs[2]), 1);
        checkOutput("dbl.addr3", 32'(addrs[3]), 1);
      end
    end
`else
    accepts = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
